// File: rtl/uart_banner_pkg.sv
// Shared types and helpers for the UART banner image: state encodings,
// data width and message byte extraction.
package uart_banner_pkg;

   localparam int unsigned DATA_BITS    = 8;
   localparam int unsigned MSG_MAX_BITS = 1024;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
   typedef enum logic [1:0] {SEND, WAIT_TX, GAP} seq_state_e;

   // Byte idx of a len-byte message, most-significant byte first.
   function automatic logic [DATA_BITS-1:0] msg_byte(input logic [MSG_MAX_BITS-1:0] msg,
                                                     input int unsigned len,
                                                     input int unsigned idx);
      int unsigned shift;
      shift = DATA_BITS * (len - 1 - idx);
      return DATA_BITS'(msg >> shift);
   endfunction

endpackage

// File: rtl/uart_banner_if.sv
// Byte handshake between the banner sequencer and the serial transmitter.
interface uart_banner_if;
   import uart_banner_pkg::*;

   logic                 start;
   logic [DATA_BITS-1:0] data;
   logic                 busy;
   logic                 done;

   modport master (output start, output data, input busy, input done);
   modport slave  (input start, input data, output busy, output done);

endinterface

// File: rtl/uart_banner_top_uart_tx.sv
// 8N1 serial transmitter, LSB first. tx is driven straight from a flop and
// only changes on bit boundaries.
module uart_tx_8n1
   import uart_banner_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] data,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BIT_W = $clog2(DATA_BITS);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
   localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLKS_PER_BIT - 2);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

   tx_state_e            state_q, state_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         div_q     <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // done is high during the final stop cycle so the next strobe lands right after the frame.
   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      done_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = START;
               shift_d   = data;
               div_d     = '0;
               bit_cnt_d = '0;
               tx_d      = 1'b0;
            end
         end
         START: begin
            if (div_q == DIV_LAST) begin
               div_d   = '0;
               state_d = DATA;
               tx_d    = shift_q[0];
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         DATA: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (bit_cnt_q == BIT_LAST) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         STOP: begin
            if (div_q == DIV_PRE) done_d = 1'b1;
            if (div_q == DIV_LAST) begin
               div_d   = '0;
               state_d = IDLE;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   assign tx   = tx_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: rtl/uart_banner_top.sv
// Board bring-up image: repeatedly sends a fixed banner on uart_tx (8N1),
// with GAP_CLKS idle cycles between repeats.
module uart_banner_top
   import uart_banner_pkg::*;
#(
   parameter int unsigned            CLKS_PER_BIT = 4,
   parameter int unsigned            MSG_LEN      = 4,
   parameter logic [8*MSG_LEN-1:0]   MSG          = 32'h4869210A,
   parameter int unsigned            GAP_CLKS     = 16
) (
   input  logic clk,
   input  logic rst_n,
   output logic uart_tx
);

   localparam int unsigned IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
   localparam int unsigned GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

   uart_banner_if hs ();

   seq_state_e           state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [GAP_W-1:0]     gap_q, gap_d;
   logic                 start_q, start_d;
   logic [DATA_BITS-1:0] data_q, data_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SEND;
         idx_q   <= '0;
         gap_q   <= '0;
         start_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         start_q <= start_d;
         data_q  <= data_d;
      end
   end

   // Sequencer: strobe one byte, wait for its frame, then advance or idle for the gap.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      start_d = 1'b0;
      data_d  = data_q;
      unique case (state_q)
         SEND: begin
            if (!hs.busy) begin
               start_d = 1'b1;
               data_d  = msg_byte(MSG_MAX_BITS'(MSG), MSG_LEN, 32'(idx_q));
               state_d = WAIT_TX;
            end
         end
         WAIT_TX: begin
            if (hs.done) begin
               if (idx_q == IDX_LAST) begin
                  idx_d = '0;
                  gap_d = '0;
                  state_d = (GAP_CLKS == 0) ? SEND : GAP;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = SEND;
               end
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               gap_d   = '0;
               state_d = SEND;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: state_d = SEND;
      endcase
   end

   assign hs.start = start_q;
   assign hs.data  = data_q;

   uart_tx_8n1 #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tx (
      .clk   (clk),
      .rst_n (rst_n),
      .start (hs.start),
      .data  (hs.data),
      .tx    (uart_tx),
      .busy  (hs.busy),
      .done  (hs.done)
   );

endmodule

// File: tb/tb_uart_banner_top.sv
// Bench for uart_banner_top: three parameterisations decoded cycle-exactly
// against a table of expected frames, plus reset corner cases.
`timescale 1ns/1ps
module tb_uart_banner_top;
   import uart_banner_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic line_a, line_b, line_c;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   uart_banner_top dut_a (.clk(clk), .rst_n(rst_n), .uart_tx(line_a));
   uart_banner_top #(.GAP_CLKS(0)) dut_b (.clk(clk), .rst_n(rst_n), .uart_tx(line_b));
   uart_banner_top #(.CLKS_PER_BIT(2), .MSG_LEN(1), .MSG(8'hA5)) dut_c (.clk(clk), .rst_n(rst_n), .uart_tx(line_c));

   // Observed-frame bundle for dut_a, handy when viewing the run.
   uart_banner_if mon ();

   typedef struct {
      int         dut;
      int         phase;
      logic [7:0] exp_byte;
      int         exp_idle;
   } frame_vec_t;

   frame_vec_t vecs[$];

   function automatic logic line_of(input int d);
      case (d)
         0:       return line_a;
         1:       return line_b;
         default: return line_c;
      endcase
   endfunction

   function automatic int cpb_of(input int d);
      return (d == 2) ? 2 : 4;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic add(input int d, input int ph, input logic [7:0] b, input int idle);
      frame_vec_t v;
      v.dut = d; v.phase = ph; v.exp_byte = b; v.exp_idle = idle;
      vecs.push_back(v);
   endtask

   // Count idle-high samples, then check start/data/stop shape and decode the byte.
   task automatic rx_frame(input int d, input logic [7:0] exp_byte, input int exp_idle, input string tag);
      int         idle = 0;
      int         cpb  = cpb_of(d);
      bit         shape_ok = 1'b1;
      logic [7:0] got = '0;
      logic       first;
      @(negedge clk);
      while (line_of(d) === 1'b1 && idle < 200) begin
         idle++;
         @(negedge clk);
      end
      check({tag, " idle"}, 32'(idle), 32'(exp_idle));
      if (idle >= 200) return;
      if (d == 0) begin mon.start = 1'b1; mon.busy = 1'b1; mon.done = 1'b0; end
      for (int s = 1; s < cpb; s++) begin
         @(negedge clk);
         if (d == 0) mon.start = 1'b0;
         if (line_of(d) !== 1'b0) shape_ok = 1'b0;
      end
      for (int b = 0; b < 8; b++) begin
         first = 1'bx;
         for (int s = 0; s < cpb; s++) begin
            @(negedge clk);
            if (s == 0) first = line_of(d);
            else if (line_of(d) !== first) shape_ok = 1'b0;
            if (s == cpb / 2) got[b] = line_of(d);
         end
      end
      for (int s = 0; s < cpb; s++) begin
         @(negedge clk);
         if (line_of(d) !== 1'b1) shape_ok = 1'b0;
      end
      if (d == 0) begin mon.data = got; mon.busy = 1'b0; mon.done = 1'b1; end
      check({tag, " byte"}, 32'(got), 32'(exp_byte));
      check({tag, " shape"}, 32'(shape_ok), 32'd1);
   endtask

   task automatic run_phase(input int d, input int ph);
      foreach (vecs[i])
         if (vecs[i].dut == d && vecs[i].phase == ph)
            rx_frame(d, vecs[i].exp_byte, vecs[i].exp_idle, $sformatf("ph%0d dut%0d vec%0d", ph, d, i));
   endtask

   initial begin
      mon.start = 1'b0; mon.busy = 1'b0; mon.done = 1'b0; mon.data = '0;

      // Default image: start bit one idle sample after release, 2 between bytes, 2+16 before repeat.
      add(0, 0, 8'h48, 1);  add(0, 0, 8'h69, 2);  add(0, 0, 8'h21, 2);
      add(0, 0, 8'h0A, 2);  add(0, 0, 8'h48, 18); add(0, 0, 8'h69, 2);
      // GAP_CLKS=0: repeat is back-to-back with the normal 2-cycle idle.
      add(1, 0, 8'h48, 1);  add(1, 0, 8'h69, 2);  add(1, 0, 8'h21, 2);
      add(1, 0, 8'h0A, 2);  add(1, 0, 8'h48, 2);  add(1, 0, 8'h69, 2);
      // Two clocks per bit, single-byte message.
      add(2, 0, 8'hA5, 1);  add(2, 0, 8'hA5, 18); add(2, 0, 8'hA5, 18); add(2, 0, 8'hA5, 18);
      // After the final reset release.
      add(0, 1, 8'h48, 1);  add(1, 1, 8'h48, 1);  add(2, 1, 8'hA5, 1);

      #1 rst_n = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("reset hold a", 32'(line_a), 32'd1);
         check("reset hold b", 32'(line_b), 32'd1);
         check("reset hold c", 32'(line_c), 32'd1);
      end
      rst_n = 1'b1;
      fork
         run_phase(0, 0);
         run_phase(1, 0);
         run_phase(2, 0);
      join

      // Reset during data bit 3 of byte 1, then restart from byte 0.
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      rx_frame(0, 8'h48, 1, "pre-reset byte0");
      repeat (3) @(negedge clk);
      check("byte1 start bit", 32'(line_a), 32'd0);
      repeat (17) @(negedge clk);
      check("byte1 bit3", 32'(line_a), 32'd1);
      #2 rst_n = 1'b0;
      #1 check("reset in bit3", 32'(line_a), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rx_frame(0, 8'h48, 1, "post-reset byte0");
      rx_frame(0, 8'h69, 2, "post-reset byte1");

      // Asynchronous reset while the line is low must raise it before the next edge.
      repeat (3) @(negedge clk);
      check("start bit before async reset", 32'(line_a), 32'd0);
      #2 rst_n = 1'b0;
      #1 check("async reset mid-cycle", 32'(line_a), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      fork
         run_phase(0, 1);
         run_phase(1, 1);
         run_phase(2, 1);
      join

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
